// File: rtl/cpu_log_pkg.sv
// rtl/cpu_log_pkg.sv - shared types and constants for the cpu_out UART logger
package cpu_log_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/cpu_out_uart_logger_sync_fifo.sv
// rtl/cpu_out_uart_logger_sync_fifo.sv - sync_fifo: single-clock FIFO, push+pop legal when full
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [DATA_W-1:0]          din,
  input  logic                       pop,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;
  logic              do_push;
  logic              do_pop;

  // When full, a same-edge pop frees the slot the push lands in.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (resetn && do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (do_pop && !do_push) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/cpu_out_uart_logger.sv
// rtl/cpu_out_uart_logger.sv - logs changes of cpu_out through a FIFO onto a UART tx line
// Optional even-parity bit after the data field when PARITY_EN is defined.
module cpu_out_uart_logger
  import cpu_log_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      cpu_out,
  input  logic                   capture_en,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);

  localparam int DIV_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] last_val;
  logic              first;
  logic              capture;
  logic              pop;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] fifo_dout;

  tx_state_t         state, state_d;
  logic [DIV_W-1:0]  div_cnt, div_d;
  logic [BIT_W-1:0]  bit_cnt, bit_d;
  logic [DATA_W-1:0] shreg, sh_d;
  logic              tx_d;
  logic              bit_end;
`ifdef PARITY_EN
  logic              par_bit, par_d;
`endif

  // Only new values are logged; the very first sample after reset always is.
  assign capture = capture_en && (first || (cpu_out != last_val));
  assign pop     = (state == IDLE) && !empty;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk    (CLK),
    .resetn (reset),
    .push   (capture),
    .din    (cpu_out),
    .pop    (pop),
    .dout   (fifo_dout),
    .full   (full),
    .empty  (empty),
    .count  (fifo_count)
  );

  always_ff @(posedge CLK) begin
    if (!reset) begin
      last_val <= '0;
      first    <= 1'b1;
      overflow <= 1'b0;
    end else if (capture) begin
      last_val <= cpu_out;
      first    <= 1'b0;
      if (full && !pop) overflow <= 1'b1;
    end
  end

  assign bit_end = (div_cnt == DIV_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state;
    div_d   = div_cnt;
    bit_d   = bit_cnt;
    sh_d    = shreg;
`ifdef PARITY_EN
    par_d   = par_bit;
`endif
    if (state != IDLE) div_d = bit_end ? '0 : div_cnt + 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_d = START;
          sh_d    = fifo_dout;
          div_d   = '0;
`ifdef PARITY_EN
          par_d   = ^fifo_dout;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          sh_d = shreg >> 1;
          if (bit_cnt == BIT_W'(DATA_W - 1)) begin
`ifdef PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_cnt + 1'b1;
          end
        end
      end
`ifdef PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP: if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // tx is registered, so it is derived from the state being entered.
    case (state_d)
      START:   tx_d = ~IDLE_LEVEL;
      DATA:    tx_d = sh_d[0];
`ifdef PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx      <= IDLE_LEVEL;
      busy    <= 1'b0;
`ifdef PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      div_cnt <= div_d;
      bit_cnt <= bit_d;
      shreg   <= sh_d;
      tx      <= tx_d;
      busy    <= (state_d != IDLE);
`ifdef PARITY_EN
      par_bit <= par_d;
`endif
    end
  end

endmodule
